// File: rtl/inst_req_ctrl.sv
// -----------------------------------------------------------------------------
// inst_req_ctrl
//
// Instruction-fetch request controller sitting between the pre-IF stage and
// the instruction SRAM bridge. It issues fetch requests while fewer than
// MAX_OUTST fetches (counting one parked in the skid buffer) are outstanding.
// It tracks the in-flight count and, on a pipeline flush, converts every
// still-pending response into a "cancelled" one that is silently discarded
// when it comes back. Live responses either pass straight through to IF
// (zero latency) or park in a one-entry buffer until IF accepts them.
//
// Handshakes: every transfer is valid/ready. A transfer happens in exactly
// the cycle where valid and ready are both high. Valid never depends on
// ready. Fetch side: sram_req_o is valid and sram_addr_ok_i is ready.
// Delivery side: inst_valid_o is valid and if_allowin_i is ready.
//
// Optional feature: define INST_REQ_CTRL_DROP_CNT_EN to build a saturating
// 32-bit counter of discarded responses on drop_cnt_o. Without the macro,
// drop_cnt_o is tied to zero.
//
// Parameters
//   MAX_OUTST       maximum accepted-but-unreturned fetches (legal 1..3)
//   DATA_W          address / instruction width
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   preif_req_i     pre-IF wants to fetch preif_addr_i this cycle
//   preif_addr_ok_o fetch accepted by memory this cycle
//   flush_i         cancel every in-flight fetch, clear the buffer
//   sram_req_o      request to memory bridge, sram_addr_o = preif_addr_i
//   sram_addr_ok_i  memory accepted the address
//   sram_data_ok_i  memory returns one instruction on sram_rdata_i
//   if_allowin_i    IF stage accepts inst_o this cycle
//   inst_valid_o    inst_o holds a live, non-cancelled instruction
//   state_o         FSM state (00 IDLE, 01 WAIT, 10 CANCEL)
//   drop_cnt_o      discarded-response count
// -----------------------------------------------------------------------------
module inst_req_ctrl #(
  parameter int MAX_OUTST = 2,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              preif_req_i,
  input  logic [DATA_W-1:0] preif_addr_i,
  input  logic              flush_i,
  output logic              preif_addr_ok_o,
  output logic              sram_req_o,
  output logic [DATA_W-1:0] sram_addr_o,
  input  logic              sram_addr_ok_i,
  input  logic              sram_data_ok_i,
  input  logic [DATA_W-1:0] sram_rdata_i,
  input  logic              if_allowin_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [1:0]        state_o,
  output logic [31:0]       drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_CANCEL = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        outst_q, outst_d;
  logic [1:0]        cancel_q, cancel_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic [2:0]        occupancy;
  logic              addr_hs;
  logic              resp;
  logic              drop;
  logic              live;

  // Occupancy counts the buffered instruction as well as in-flight fetches,
  // so a response can never arrive with nowhere to go except when the
  // remaining in-flight response meets a full buffer (see assertion below).
  assign occupancy       = {1'b0, outst_q} + {2'b00, buf_valid_q};
  assign sram_req_o      = preif_req_i & ~flush_i & (occupancy < 3'(MAX_OUTST));
  assign sram_addr_o     = preif_addr_i;
  assign addr_hs         = sram_req_o & sram_addr_ok_i;
  assign preif_addr_ok_o = addr_hs;

  // A response with nothing outstanding is ignored so outst never wraps.
  assign resp = sram_data_ok_i & (outst_q != 2'd0);
  // A response is discarded if it lands in a flush cycle or is still owed
  // to an earlier flush.
  assign drop = resp & (flush_i | (cancel_q != 2'd0));
  assign live = resp & ~flush_i & (cancel_q == 2'd0);

  assign inst_valid_o = ~flush_i & (buf_valid_q | live);
  assign inst_o       = buf_valid_q ? buf_data_q : sram_rdata_i;
  assign state_o      = state_q;

  always_comb begin
    outst_d     = outst_q;
    cancel_d    = cancel_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    state_d     = state_q;

    if (addr_hs && !resp) begin
      outst_d = outst_q + 2'd1;
    end else if (!addr_hs && resp) begin
      outst_d = outst_q - 2'd1;
    end

    // Flush reloads rather than adds: outst already includes any responses
    // still owed to an earlier flush, so merged counts stay exact.
    if (flush_i) begin
      cancel_d = outst_q - {1'b0, resp};
    end else if (drop) begin
      cancel_d = cancel_q - 2'd1;
    end

    if (flush_i) begin
      buf_valid_d = 1'b0;
    end else if (buf_valid_q) begin
      if (if_allowin_i) begin
        buf_valid_d = 1'b0;
      end
    end else if (live && !if_allowin_i) begin
      buf_valid_d = 1'b1;
      buf_data_d  = sram_rdata_i;
    end

    if (flush_i) begin
      if (cancel_d != 2'd0) begin
        state_d = ST_CANCEL;
      end else if (outst_d != 2'd0) begin
        state_d = ST_WAIT;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (outst_d != 2'd0) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (outst_d == 2'd0) state_d = ST_IDLE;
        end
        ST_CANCEL: begin
          if (cancel_d == 2'd0) begin
            state_d = (outst_d != 2'd0) ? ST_WAIT : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      outst_q     <= 2'd0;
      cancel_q    <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      cancel_q    <= cancel_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

`ifdef INST_REQ_CTRL_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 32'd0;
    end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 32'd0;
`endif

  // A live response must never arrive while the buffer still holds one:
  // there is only one slot, and the buffered instruction must go out first.
  buf_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_valid_q && live));

endmodule

// File: tb/tb_inst_req_ctrl.sv
module tb_inst_req_ctrl;

  localparam int MAX = 2;

  logic        clk;
  logic        rst_n;
  logic        preif_req_i;
  logic [31:0] preif_addr_i;
  logic        flush_i;
  logic        preif_addr_ok_o;
  logic        sram_req_o;
  logic [31:0] sram_addr_o;
  logic        sram_addr_ok_i;
  logic        sram_data_ok_i;
  logic [31:0] sram_rdata_i;
  logic        if_allowin_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [1:0]  state_o;
  logic [31:0] drop_cnt_o;

  inst_req_ctrl #(.MAX_OUTST(MAX), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .preif_req_i     (preif_req_i),
    .preif_addr_i    (preif_addr_i),
    .flush_i         (flush_i),
    .preif_addr_ok_o (preif_addr_ok_o),
    .sram_req_o      (sram_req_o),
    .sram_addr_o     (sram_addr_o),
    .sram_addr_ok_i  (sram_addr_ok_i),
    .sram_data_ok_i  (sram_data_ok_i),
    .sram_rdata_i    (sram_rdata_i),
    .if_allowin_i    (if_allowin_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .state_o         (state_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // inflight: one entry per accepted fetch, oldest first; 1 = live, 0 = owed
  //           to a flush and to be thrown away when it returns.
  // exp_q:    instructions the IF stage should be offered, oldest first.
  bit          inflight[$];
  logic [31:0] exp_q[$];
  int          drops;
  int          checks;
  int          errors;

  function automatic logic [1:0] model_state();
    int n_cancel;
    n_cancel = 0;
    foreach (inflight[i]) if (!inflight[i]) n_cancel++;
    if (n_cancel > 0) return 2'b10;
    if (inflight.size() > 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_drop();
`ifdef INST_REQ_CTRL_DROP_CNT_EN
    return 32'(drops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    exp_q.delete();
    drops = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model to what the coming edge should produce.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic fl,
                     input logic aok, input logic dok, input logic [31:0] rd,
                     input logic alw);
    int   occ;
    logic e_req, e_aok, resp, live, e_valid, had;
    logic [31:0] e_inst;
    @(posedge clk);
    #1;
    preif_req_i    = req;
    preif_addr_i   = addr;
    flush_i        = fl;
    sram_addr_ok_i = aok;
    sram_data_ok_i = dok;
    sram_rdata_i   = rd;
    if_allowin_i   = alw;
    #3;
    occ     = inflight.size() + exp_q.size();
    e_req   = req && !fl && (occ < MAX);
    e_aok   = e_req && aok;
    resp    = dok && (inflight.size() > 0);
    live    = resp && !fl && inflight[0];
    e_valid = !fl && ((exp_q.size() > 0) || live);
    e_inst  = (exp_q.size() > 0) ? exp_q[0] : rd;

    chk("sram_req", 32'(sram_req_o), 32'(e_req));
    chk("addr_ok", 32'(preif_addr_ok_o), 32'(e_aok));
    chk("sram_addr", sram_addr_o, addr);
    chk("inst_valid", 32'(inst_valid_o), 32'(e_valid));
    if (e_valid) chk("inst", inst_o, e_inst);
    chk("state", 32'(state_o), 32'(model_state()));
    chk("drop_cnt", drop_cnt_o, exp_drop());

    had = exp_q.size() > 0;
    if (resp) begin
      void'(inflight.pop_front());
      if (!live) drops++;
    end
    if (fl) begin
      foreach (inflight[i]) inflight[i] = 1'b0;
      exp_q.delete();
    end else begin
      if (had && alw) void'(exp_q.pop_front());
      if (live && !had && !alw) exp_q.push_back(rd);
    end
    if (e_aok) inflight.push_back(1'b1);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Empty the buffer first, then return every outstanding response.
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || inflight.size() > 0) && guard < 20) begin
      if (exp_q.size() > 0) idle_cyc();
      else cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom, 1'b1);
      guard++;
    end
    if (guard >= 20) chk("drain_timeout", 32'(guard), 32'd0);
    idle_cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_req, r_fl, r_aok, r_dok, r_alw;
    logic [31:0] r_addr;
    checks = 0;
    errors = 0;
    model_reset();
    rst_n          = 1'b0;
    preif_req_i    = 1'b0;
    preif_addr_i   = 32'h0;
    flush_i        = 1'b0;
    sram_addr_ok_i = 1'b0;
    sram_data_ok_i = 1'b0;
    sram_rdata_i   = 32'h0;
    if_allowin_i   = 1'b0;

    // reset state
    #2;
    chk("rst_sram_req", 32'(sram_req_o), 32'd0);
    chk("rst_addr_ok", 32'(preif_addr_ok_o), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_drop_cnt", drop_cnt_o, 32'd0);
    preif_req_i = 1'b1;
    #1;
    chk("rst_sram_req_comb", 32'(sram_req_o), 32'd1);
    preif_req_i = 1'b0;
    #20;
    rst_n = 1'b1;

    // back-to-back fetch, data two cycles after each accept
    cyc(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h1C00_0004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("b2b_outst_peak", 32'(inflight.size()), 32'd2);
    cyc(1'b1, 32'h1C00_0008, 1'b0, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1);
    cyc(1'b1, 32'h1C00_0008, 1'b0, 1'b1, 1'b1, 32'hAAAA_0002, 1'b1);
    drain();

    // flush with two outstanding, both responses dropped
    cyc(1'b1, 32'h1C00_0010, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h1C00_0014, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0001, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0002, 1'b1);
    idle_cyc();
    chk("flush_drop_cnt", drop_cnt_o, exp_drop());
    chk("flush_state_idle", 32'(state_o), 32'd0);

    // flush coincident with a response: one more drop, then a live fetch
    cyc(1'b1, 32'h1C00_0020, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h1C00_0024, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h1C00_0028, 1'b1, 1'b1, 1'b1, 32'hDEAD_0003, 1'b1);
    cyc(1'b1, 32'h1C00_8000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0004, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    drain();

    // IF stalls with a buffered instruction; fetch blocked while full
    cyc(1'b1, 32'h1C00_0030, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1C00_0034, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1C00_0038, 1'b0, 1'b1, 1'b1, 32'h0280_0000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1C00_0038, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0280_0004, 1'b1);
    drain();

    // asynchronous reset mid-transaction with the buffer full
    cyc(1'b1, 32'h1C00_0040, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1C00_0044, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0001, 1'b0);
    @(posedge clk);
    #1;
    preif_req_i    = 1'b0;
    flush_i        = 1'b0;
    sram_addr_ok_i = 1'b0;
    sram_data_ok_i = 1'b0;
    if_allowin_i   = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(inst_valid_o), 32'd1);
    chk("pre_rst_inst", inst_o, 32'hBEEF_0001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_sram_req", 32'(sram_req_o), 32'd0);
    chk("mid_rst_addr_ok", 32'(preif_addr_ok_o), 32'd0);
    chk("mid_rst_drop_cnt", drop_cnt_o, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r_req  = 1'($urandom_range(0, 3) != 0);
      r_addr = $urandom;
      r_fl   = 1'($urandom_range(0, 15) == 0);
      r_aok  = 1'($urandom_range(0, 3) != 0);
      r_dok  = 1'((inflight.size() > 0) && ($urandom_range(0, 2) != 0));
      r_alw  = 1'($urandom_range(0, 2) != 0);
      // keep a live response from landing on a full buffer
      if ((exp_q.size() > 0) && !r_fl && (inflight.size() > 0) && inflight[0]) r_dok = 1'b0;
      cyc(r_req, r_addr, r_fl, r_aok, r_dok, $urandom, r_alw);
    end
    drain();
    chk("final_state", 32'(state_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
